// File: rtl/exec_stage.sv
// Execute stage: ALU evaluation feeding a two-entry (main + skid) output buffer,
// plus the architectural carry/zero flag register updated on commit.

module exec_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        carry,
  output logic        zero
);
  logic [4:0]  sh;
  logic [32:0] shl_w;
  logic [32:0] shr_w;
  logic [32:0] sar_w;

  // Shifts use a 33-bit window so the carry is the last bit shifted out.
  assign sh    = b[4:0];
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign sar_w = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      4'd1: {carry, result} = {1'b0, a} + {1'b0, b};
      4'd2: begin
        result = a - b;
        carry  = (a < b);
      end
      4'd3: begin
        result = shl_w[31:0];
        carry  = shl_w[32];
      end
      4'd4: begin
        result = shr_w[32:1];
        carry  = shr_w[0];
      end
      4'd5: begin
        result = sar_w[32:1];
        carry  = sar_w[0];
      end
      4'd6: result = a & b;
      4'd7: result = a | b;
      4'd8: result = a ^ b;
      4'd9: result = ~a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module exec_stage #(
  parameter int REGIDX_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [31:0]         in_a,
  input  logic [31:0]         in_b,
  input  logic [REGIDX_W-1:0] in_rd,
  input  logic                in_wr_en,
  input  logic                in_setflags,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [REGIDX_W-1:0] out_rd,
  output logic                out_wr_en,
  output logic                out_carry,
  output logic                out_zero,
  output logic                flag_carry,
  output logic                flag_zero
);
  typedef struct packed {
    logic [31:0]         result;
    logic                carry;
    logic                zero;
    logic [REGIDX_W-1:0] rd;
    logic                wr_en;
    logic                setflags;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   m_v_q, m_v_d, s_v_q, s_v_d;
  logic   flag_carry_q, flag_carry_d, flag_zero_q, flag_zero_d;
  logic   accept, commit;
  logic [31:0] alu_result;
  logic        alu_carry, alu_zero;

  exec_alu u_alu (
    .op     (in_opcode),
    .a      (in_a),
    .b      (in_b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.result   = alu_result;
    in_entry.carry    = alu_carry;
    in_entry.zero     = alu_zero;
    in_entry.rd       = in_rd;
    in_entry.wr_en    = in_wr_en;
    in_entry.setflags = in_setflags;
  end

  // Flush gates both handshakes, so it suppresses accept and commit by itself.
  assign in_ready  = ~s_v_q & ~flush;
  assign out_valid = m_v_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign commit    = out_valid & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    m_v_d        = m_v_q;
    s_v_d        = s_v_q;
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;

    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (commit) begin
      if (main_q.setflags) begin
        flag_carry_d = main_q.carry;
        flag_zero_d  = main_q.zero;
      end
      if (s_v_q) begin
        main_d = skid_q;
        s_v_d  = 1'b0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_v_q) begin
        main_d = in_entry;
        m_v_d  = 1'b1;
      end else begin
        skid_d = in_entry;
        s_v_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      m_v_q        <= 1'b0;
      s_v_q        <= 1'b0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      m_v_q        <= m_v_d;
      s_v_q        <= s_v_d;
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
    end
  end

  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_wr_en  = main_q.wr_en;
  assign out_carry  = main_q.carry;
  assign out_zero   = main_q.zero;
  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;
endmodule
